// File: rtl/display_sched.sv
// Display scheduler for a cooking appliance front panel.
// Chooses which value source drives the display (wall clock, keypad entry,
// cook timer) and produces the blink strobe shown when cooking finishes.
module display_sched #(
  parameter logic [15:0] KEY_TIMEOUT = 16'd5000,
  parameter logic [15:0] DONE_HOLD   = 16'd3000,
  parameter logic [15:0] BLINK_DIV   = 16'd500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic       start,
  input  logic       clear,
  input  logic       done,
  output logic       ShowC,
  output logic       ShowK,
  output logic       ShowT,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    S_CLOCK = 2'b00,
    S_KEYIN = 2'b01,
    S_COOK  = 2'b10,
    S_DONE  = 2'b11
  } stateT;

  stateT         state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [CntW-1:0] div, divNext;
  logic          blinkNext;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLOCK;
    end else begin
      state <= stateNext;
    end
  end

  // Next state, shared idle/hold counter and blink divider
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    divNext   = div;
    blinkNext = blink;

    case (state)
      S_CLOCK: begin
        if (key_valid) stateNext = S_KEYIN;
      end
      S_KEYIN: begin
        if (clear)                                  stateNext = S_CLOCK;
        else if (start)                             stateNext = S_COOK;
        else if (key_valid)                         cntNext   = '0;
        else if (cnt == KEY_TIMEOUT - CntW'(1))     stateNext = S_CLOCK;
        else                                        cntNext   = cnt + CntW'(1);
      end
      S_COOK: begin
        if (clear)     stateNext = S_CLOCK;
        else if (done) stateNext = S_DONE;
      end
      S_DONE: begin
        if (clear)                                stateNext = S_CLOCK;
        else if (key_valid)                       stateNext = S_KEYIN;
        else if (cnt == DONE_HOLD - CntW'(1))     stateNext = S_CLOCK;
        else begin
          cntNext = cnt + CntW'(1);
          if (div == BLINK_DIV - CntW'(1)) begin
            divNext   = '0;
            blinkNext = ~blink;
          end else begin
            divNext = div + CntW'(1);
          end
        end
      end
    endcase

    // Every state entry restarts the counter and divider; blink starts lit in DONE only
    if (stateNext != state) begin
      cntNext   = '0;
      divNext   = '0;
      blinkNext = (stateNext == S_DONE);
    end
  end

  // Counter, divider and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div   <= '0;
      blink <= 1'b0;
      mode  <= 2'b00;
      ShowC <= 1'b1;
      ShowK <= 1'b0;
      ShowT <= 1'b0;
    end else begin
      cnt   <= cntNext;
      div   <= divNext;
      blink <= blinkNext;
      mode  <= 2'(stateNext);
      ShowC <= (stateNext == S_CLOCK);
      ShowK <= (stateNext == S_KEYIN);
      ShowT <= (stateNext == S_COOK) || (stateNext == S_DONE);
    end
  end

endmodule

// File: tb/tb_display_sched.sv
// Self-checking bench for display_sched: a cycle model fills a scoreboard
// queue on each rising edge, scenario tasks pop and compare on falling edges.
module tb_display_sched;

  localparam logic [15:0] KT = 16'd8;
  localparam logic [15:0] DH = 16'd6;
  localparam logic [15:0] BD = 16'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_valid = 1'b0, start = 1'b0, clear = 1'b0, done = 1'b0;
  logic       ShowC, ShowK, ShowT, blink;
  logic [1:0] mode;

  int nChk = 0;
  int nFail = 0;
  bit chkOn = 1'b0;

  typedef struct packed {
    logic [1:0] mode;
    logic       showC;
    logic       showK;
    logic       showT;
    logic       blink;
  } expT;

  expT sbq[$];
  expT e;

  display_sched #(.KEY_TIMEOUT(KT), .DONE_HOLD(DH), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .start(start),
    .clear(clear), .done(done), .ShowC(ShowC), .ShowK(ShowK), .ShowT(ShowT),
    .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  // Reference model: 0 CLOCK, 1 KEYIN, 2 COOK, 3 DONE
  int mSt, mCnt, mDiv;
  bit mBlink;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSt = 0; mCnt = 0; mDiv = 0; mBlink = 0;
    end else begin
      int nxt;
      nxt = mSt;
      case (mSt)
        0: if (key_valid) nxt = 1;
        1: begin
          if (clear) nxt = 0;
          else if (start) nxt = 2;
          else if (key_valid) mCnt = 0;
          else if (mCnt + 1 >= int'(KT)) nxt = 0;
          else mCnt++;
        end
        2: begin
          if (clear) nxt = 0;
          else if (done) nxt = 3;
        end
        default: begin
          if (clear) nxt = 0;
          else if (key_valid) nxt = 1;
          else if (mCnt + 1 >= int'(DH)) nxt = 0;
          else begin
            mCnt++;
            mDiv++;
            if (mDiv >= int'(BD)) begin mDiv = 0; mBlink = !mBlink; end
          end
        end
      endcase
      if (nxt != mSt) begin
        mSt = nxt; mCnt = 0; mDiv = 0; mBlink = (nxt == 3);
      end
      sbq.push_back('{mode: 2'(mSt), showC: (mSt == 0), showK: (mSt == 1),
                      showT: (mSt >= 2), blink: mBlink});
    end
  end

  // Display select must be one-hot every cycle
  always @(negedge clk) begin
    if (chkOn) begin
      nChk++;
      assert ($onehot({ShowC, ShowK, ShowT})) else begin
        nFail++;
        $display("FAIL onehot: Show{C,K,T}=%b required exactly one set", {ShowC, ShowK, ShowT});
      end
    end
  end

  task automatic setIn(input bit kv, input bit st, input bit cl, input bit dn);
    key_valid = kv; start = st; clear = cl; done = dn;
  endtask

  task automatic test_reset();
    setIn(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nChk++;
    if ({mode, ShowC, ShowK, ShowT, blink} !== 6'b00_100_0) begin
      nFail++;
      $display("FAIL reset_values: got %b required %b", {mode, ShowC, ShowK, ShowT, blink}, 6'b00_100_0);
    end
    rst_n = 1'b1;
    chkOn = 1'b1;
  endtask

  // Entry to KEYIN on key, then idle timeout back to CLOCK after 8 cycles
  task automatic test_key_timeout();
    int inKey;
    inKey = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      nChk++;
      if (sbq.size() == 0) begin
        nFail++; $display("FAIL timeout_sb: scoreboard empty at cycle %0d", c);
      end else begin
        e = sbq.pop_front();
        if ({mode, ShowC, ShowK, ShowT, blink} !== e) begin
          nFail++;
          $display("FAIL timeout_sb c%0d: got %b required %b", c, {mode, ShowC, ShowK, ShowT, blink}, e);
        end
      end
      if (mode == 2'b01) inKey++;
      if (c == 3) begin
        nChk++;
        if (mode !== 2'b01 || ShowK !== 1'b1) begin
          nFail++; $display("FAIL key_entry: mode=%b ShowK=%b required 01/1", mode, ShowK);
        end
      end
      if (c == 11) begin
        nChk++;
        if (mode !== 2'b00 || ShowC !== 1'b1) begin
          nFail++; $display("FAIL key_timeout: mode=%b ShowC=%b required 00/1", mode, ShowC);
        end
      end
      setIn(c == 2, 0, 0, 0);
    end
    nChk++;
    if (inKey != 8) begin
      nFail++; $display("FAIL key_dwell: %0d cycles in KEYIN required 8", inKey);
    end
  endtask

  // Repeated keys keep KEYIN alive; start moves to COOK
  task automatic test_key_hold_start();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      nChk++;
      if (sbq.size() == 0) begin
        nFail++; $display("FAIL hold_sb: scoreboard empty at cycle %0d", c);
      end else begin
        e = sbq.pop_front();
        if ({mode, ShowC, ShowK, ShowT, blink} !== e) begin
          nFail++;
          $display("FAIL hold_sb c%0d: got %b required %b", c, {mode, ShowC, ShowK, ShowT, blink}, e);
        end
      end
      if (c >= 1 && c <= 8 && mode !== 2'b01) begin
        nChk++; nFail++;
        $display("FAIL hold_keyin c%0d: mode=%b required 01", c, mode);
      end
      if (c == 9) begin
        nChk++;
        if (mode !== 2'b10 || ShowT !== 1'b1) begin
          nFail++; $display("FAIL cook_entry: mode=%b ShowT=%b required 10/1", mode, ShowT);
        end
      end
      setIn(c == 0 || c == 5, c == 8, 0, 0);
    end
  endtask

  // In COOK, key/start ignored; done enters DONE with blink 1,1,0,0,1,1
  task automatic test_done_blink();
    logic [5:0] seq;
    seq = '0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      nChk++;
      if (sbq.size() == 0) begin
        nFail++; $display("FAIL done_sb: scoreboard empty at cycle %0d", c);
      end else begin
        e = sbq.pop_front();
        if ({mode, ShowC, ShowK, ShowT, blink} !== e) begin
          nFail++;
          $display("FAIL done_sb c%0d: got %b required %b", c, {mode, ShowC, ShowK, ShowT, blink}, e);
        end
      end
      if ((c == 1 || c == 2) && mode !== 2'b10) begin
        nChk++; nFail++;
        $display("FAIL cook_ignore c%0d: mode=%b required 10", c, mode);
      end
      if (c >= 3 && c <= 8) begin
        if (mode !== 2'b11 || ShowT !== 1'b1) begin
          nChk++; nFail++;
          $display("FAIL done_mode c%0d: mode=%b ShowT=%b required 11/1", c, mode, ShowT);
        end
        seq[8 - c] = blink;
      end
      if (c == 9) begin
        nChk++;
        if (mode !== 2'b00 || blink !== 1'b0) begin
          nFail++; $display("FAIL done_exit: mode=%b blink=%b required 00/0", mode, blink);
        end
      end
      setIn(c == 0, c == 1, 0, c == 2);
    end
    nChk++;
    if (seq !== 6'b110011) begin
      nFail++; $display("FAIL blink_seq: got %b required 110011", seq);
    end
  endtask

  // Same-cycle collisions and exits from DONE
  task automatic test_priority();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      nChk++;
      if (sbq.size() == 0) begin
        nFail++; $display("FAIL prio_sb: scoreboard empty at cycle %0d", c);
      end else begin
        e = sbq.pop_front();
        if ({mode, ShowC, ShowK, ShowT, blink} !== e) begin
          nFail++;
          $display("FAIL prio_sb c%0d: got %b required %b", c, {mode, ShowC, ShowK, ShowT, blink}, e);
        end
      end
      if (c == 3 || c == 8 || c == 16) begin
        nChk++;
        if (mode !== 2'b00) begin
          nFail++; $display("FAIL prio_clear c%0d: mode=%b required 00", c, mode);
        end
      end
      if (c == 14) begin
        nChk++;
        if (mode !== 2'b01 || blink !== 1'b0) begin
          nFail++; $display("FAIL done_key: mode=%b blink=%b required 01/0", mode, blink);
        end
      end
      setIn(c == 0 || c == 4 || c == 9 || c == 13,
            c == 2 || c == 5 || c == 10,
            c == 2 || c == 7 || c == 15,
            c == 7 || c == 11);
    end
  endtask

  // Asynchronous reset mid-COOK, then start after release is ignored
  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChk++;
      if (sbq.size() == 0) begin
        nFail++; $display("FAIL ares_sb: scoreboard empty at cycle %0d", c);
      end else begin
        e = sbq.pop_front();
        if ({mode, ShowC, ShowK, ShowT, blink} !== e) begin
          nFail++;
          $display("FAIL ares_sb c%0d: got %b required %b", c, {mode, ShowC, ShowK, ShowT, blink}, e);
        end
      end
      setIn(c == 0, c == 1, 0, 0);
    end
    @(negedge clk);
    nChk++;
    if (mode !== 2'b10) begin
      nFail++; $display("FAIL ares_cook: mode=%b required 10", mode);
    end
    sbq.delete();
    #2 rst_n = 1'b0;
    #1;
    nChk++;
    if (mode !== 2'b00 || ShowC !== 1'b1 || ShowT !== 1'b0) begin
      nFail++; $display("FAIL ares_immediate: mode=%b ShowC=%b ShowT=%b required 00/1/0", mode, ShowC, ShowT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    for (int c = 0; c < 5; c++) begin
      setIn(0, c == 0, c == 2, c == 1);
      @(negedge clk);
      nChk++;
      if (sbq.size() == 0) begin
        nFail++; $display("FAIL post_sb: scoreboard empty at cycle %0d", c);
      end else begin
        e = sbq.pop_front();
        if ({mode, ShowC, ShowK, ShowT, blink} !== e) begin
          nFail++;
          $display("FAIL post_sb c%0d: got %b required %b", c, {mode, ShowC, ShowK, ShowT, blink}, e);
        end
      end
      if (mode !== 2'b00 || ShowC !== 1'b1) begin
        nChk++; nFail++;
        $display("FAIL post_clock c%0d: mode=%b ShowC=%b required 00/1", c, mode, ShowC);
      end
    end
    setIn(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_key_timeout();
    test_key_hold_start();
    test_done_blink();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
